// File: rtl/ps2_rx_fifo_pkg.sv
// Shared definitions for the PS/2 receiver: FSM states, frame/entry geometry and
// the frame-to-entry check helper.
package ps2_rx_fifo_pkg;

  localparam int PS2_FRAME_BITS = 10;  // 8 data, parity, stop (start bit not stored)
  localparam int PS2_ENTRY_W    = 10;
  localparam int ENT_DATA_LSB   = 0;
  localparam int ENT_PERR_BIT   = 8;
  localparam int ENT_FERR_BIT   = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  // Odd parity over data+parity; a low stop bit is a framing error.
  function automatic rx_entry_t make_entry(input logic [PS2_FRAME_BITS-1:0] frame);
    rx_entry_t e;
    e.data = frame[7:0];
    e.perr = ~^frame[8:0];
    e.ferr = ~frame[9];
    return e;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_mem.sv
// Show-ahead synchronous FIFO with occupancy count; the head register holds its
// last value once the FIFO drains.
module ps2_rx_fifo_mem #(
  parameter int AW = 4,
  parameter int W  = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Next head: the entry behind the popped one, or the bypassed write when
      // that entry is the one being written this cycle.
      if (empty) begin
        if (push) head <= din;
      end else if (pop) begin
        if (count > (AW+1)'(1)) head <= mem[rd_ptr + 1'b1];
        else if (push)          head <= din;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: ps2_clk glitch filter, frame FSM, parity/stop
// checks and a show-ahead FIFO. Define PS2_RX_TIMEOUT_EN to abort stalled frames.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_AW        = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  input  logic           rx_en,
  input  logic           rd_en,
  output logic [7:0]     dout,
  output logic           dout_perr,
  output logic           dout_ferr,
  output logic           empty,
  output logic           full,
  output logic [FIFO_AW:0] count,
  output logic           rx_done,
  output logic           overflow,
  output logic           rx_timeout,
  input  logic           clr_flags
);

  logic [FILTER_LEN-1:0]     filt_sr;
  logic                      f_clk, f_clk_next, fall;
  rx_state_t                 state, state_nxt;
  logic [3:0]                bit_cnt;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic                      tmo, push_req, ovf_set;
  rx_entry_t                 entry;
  logic [PS2_ENTRY_W-1:0]    head;

  // f_clk only moves on a unanimous filter window, so short glitches are held off.
  always_comb begin
    f_clk_next = f_clk;
    if (&filt_sr)       f_clk_next = 1'b1;
    else if (~|filt_sr) f_clk_next = 1'b0;
  end
  assign fall = f_clk & ~f_clk_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_sr <= '0;
      f_clk   <= 1'b0;
    end else begin
      filt_sr <= {filt_sr[FILTER_LEN-2:0], ps2_clk};
      f_clk   <= f_clk_next;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fall && rx_en && !ps2_data) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tmo) state_nxt = ST_IDLE;
                else if (fall && bit_cnt == 4'(PS2_FRAME_BITS-1)) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_done  = (state == ST_CHECK);
    push_req = rx_done & ~full;
    ovf_set  = rx_done & full;
  end

  // Frame is shifted in LSB first, so the stop bit ends up in frame[9].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      frame   <= '0;
    end else if (state != ST_SHIFT) begin
      bit_cnt <= '0;
    end else if (fall) begin
      frame   <= {ps2_data, frame[PS2_FRAME_BITS-1:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)          overflow <= 1'b0;
    else if (ovf_set)   overflow <= 1'b1;
    else if (clr_flags) overflow <= 1'b0;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge reset)
    if (reset)                           tmo_cnt <= '0;
    else if (state != ST_SHIFT || fall)  tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + 1'b1;

  assign tmo = (state == ST_SHIFT) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset)
    if (reset)          rx_timeout <= 1'b0;
    else if (tmo)       rx_timeout <= 1'b1;
    else if (clr_flags) rx_timeout <= 1'b0;
`else
  assign tmo        = 1'b0;
  assign rx_timeout = 1'b0;
`endif

  assign entry = make_entry(frame);

  ps2_rx_fifo_mem #(.AW(FIFO_AW), .W(PS2_ENTRY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (push_req),
    .rd_en (rd_en),
    .din   (entry),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign dout      = head[ENT_DATA_LSB +: 8];
  assign dout_perr = head[ENT_PERR_BIT];
  assign dout_ferr = head[ENT_FERR_BIT];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised bench for ps2_rx_fifo against a queue-based model of the FIFO and
// frame checks. Define PS2_RX_TIMEOUT_EN to also exercise the stall abort.
module tb_ps2_rx_fifo;

  localparam int FL    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 400;

  logic clk = 1'b0;
  logic reset, ps2_clk, ps2_data, rx_en, rd_en, clr_flags;
  logic [7:0] dout;
  logic dout_perr, dout_ferr, empty, full, rx_done, overflow, rx_timeout;
  logic [AW:0] count;

  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_en(rx_en), .rd_en(rd_en), .dout(dout), .dout_perr(dout_perr),
    .dout_ferr(dout_ferr), .empty(empty), .full(full), .count(count),
    .rx_done(rx_done), .overflow(overflow), .rx_timeout(rx_timeout),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } ent_t;

  ent_t q[$];
  ent_t last_head, pend;
  logic exp_ovf, exp_done, full_pre;
  int   ncnt = 0, push_at = -1, done_seen = 0;
  int   vecs = 0, errs = 0;
  bit   rnd_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // One PS/2 bit: high phase (optionally with a sub-filter low glitch), then low phase.
  task automatic ps2_bit(input logic b, input bit last, input bit glitch, input bit rd_chk);
    int hi, lo;
    hi = $urandom_range(FL + 2, FL + 6);
    lo = $urandom_range(FL + 2, FL + 6);
    ps2_data = b;
    repeat (hi) @(posedge clk);
    if (glitch) begin
      #1 ps2_clk = 1'b0;
      repeat (FL - 1) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (hi) @(posedge clk);
    end
    #1 ps2_clk = 1'b0;
    if (last) push_at = ncnt + FL + 2;
    if (last && rd_chk) begin
      repeat (FL + 1) @(posedge clk);
      #1 rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      repeat (lo - FL - 2) @(posedge clk);
    end else begin
      repeat (lo) @(posedge clk);
    end
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input logic st = 1'b0, input int nbits = 11,
                            input int glitch_at = -1, input bit rd_chk = 1'b0);
    logic [10:0] bits;
    bit accepted;
    bits = {stp, par, d, st};
    accepted = rx_en && !st;
    if (accepted) pend = '{ferr: ~stp, perr: ~^{d, par}, data: d};
    for (int i = 0; i < nbits; i++)
      ps2_bit(bits[i], accepted && (i == 10), glitch_at == i, rd_chk);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (FL + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rx_en = 1'b1;
    rd_en = 1'b0; clr_flags = 1'b0; last_head = '0; exp_ovf = 1'b0;

    // Model + per-cycle compare, sampled on the falling edge.
    fork
      forever begin
        @(negedge clk);
        ncnt++;
        if (rx_done === 1'b1) done_seen++;
        if (reset) begin
          q.delete();
          last_head = '0;
          exp_ovf   = 1'b0;
        end else begin
          exp_done = (ncnt == push_at);
          chk("dout",      32'(dout),      32'(last_head.data));
          chk("dout_perr", 32'(dout_perr), 32'(last_head.perr));
          chk("dout_ferr", 32'(dout_ferr), 32'(last_head.ferr));
          chk("count",     32'(count),     32'(q.size()));
          chk("empty",     32'(empty),     32'(q.size() == 0));
          chk("full",      32'(full),      32'(q.size() == DEPTH));
          chk("rx_done",   32'(rx_done),   32'(exp_done));
          chk("overflow",  32'(overflow),  32'(exp_ovf));
`ifndef PS2_RX_TIMEOUT_EN
          chk("rx_timeout", 32'(rx_timeout), 32'd0);
`endif
          full_pre = (q.size() == DEPTH);
          if (rd_en && q.size() > 0) void'(q.pop_front());
          if (exp_done && !full_pre) q.push_back(pend);
          if (exp_done && full_pre) exp_ovf = 1'b1;
          else if (clr_flags)       exp_ovf = 1'b0;
          if (q.size() > 0) last_head = q[0];
        end
      end
    join_none

    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    do_reset();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);

    // Clean frame
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("lit_1c_data", 32'(dout), 32'h1C);
    chk("lit_1c_err",  32'({dout_ferr, dout_perr}), 32'd0);
    chk("lit_1c_cnt",  32'(count), 32'd1);
    chk("lit_1c_done", 32'(done_seen), 32'd1);
    pop1();
    chk("lit_pop_empty", 32'(empty), 32'd1);

    // Parity error (0 is the wrong bit for A5), then framing error
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("lit_a5_perr", 32'(dout_perr), 32'd1);
    send_frame(8'h3C, good_par(8'h3C), 1'b0);
    pop1();
    chk("lit_3c_data", 32'(dout), 32'h3C);
    chk("lit_3c_ferr", 32'({dout_ferr, dout_perr}), 32'b10);
    pop1();

    // Glitch mid-bit
    send_frame(8'h6B, good_par(8'h6B), 1'b1, 1'b0, 11, 4);
    chk("lit_glitch_data", 32'(dout), 32'h6B);
    chk("lit_glitch_perr", 32'(dout_perr), 32'd0);
    pop1();

    // Frames that must not start
    rx_en = 1'b0;
    send_frame(8'h77, good_par(8'h77), 1'b1);
    rx_en = 1'b1;
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1);
    chk("lit_nostart_cnt", 32'(count), 32'd0);

    // Overflow
    for (int i = 0; i <= DEPTH; i++)
      send_frame(8'h10 + 8'(i), good_par(8'h10 + 8'(i)), 1'b1);
    chk("lit_ovf_cnt",  32'(count), 32'(DEPTH));
    chk("lit_ovf_full", 32'(full), 32'd1);
    chk("lit_ovf_flag", 32'(overflow), 32'd1);
    chk("lit_ovf_head", 32'(dout), 32'h10);
    clr_flags = 1'b1;
    @(posedge clk);
    #1 clr_flags = 1'b0;
    chk("lit_ovf_clr", 32'(overflow), 32'd0);
    repeat (DEPTH) pop1();
    chk("lit_drain_empty", 32'(empty), 32'd1);

    // Pop in the push cycle at count 3
    for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), good_par(8'h40 + 8'(i)), 1'b1);
    send_frame(8'h43, good_par(8'h43), 1'b1, 1'b0, 11, -1, 1'b1);
    chk("lit_rdwr_cnt", 32'(count), 32'd3);
    chk("lit_rdwr_head", 32'(dout), 32'h41);
    repeat (3) pop1();
    pop1();
    chk("lit_rd_empty_cnt", 32'(count), 32'd0);
    chk("lit_rd_empty_hold", 32'(dout), 32'h43);

`ifdef PS2_RX_TIMEOUT_EN
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 4);
    for (int i = 0; i < TMO + 200 && rx_timeout !== 1'b1; i++) @(posedge clk);
    #1;
    chk("lit_tmo_flag", 32'(rx_timeout), 32'd1);
    chk("lit_tmo_cnt",  32'(count), 32'd0);
    clr_flags = 1'b1;
    @(posedge clk);
    #1 clr_flags = 1'b0;
    chk("lit_tmo_clr", 32'(rx_timeout), 32'd0);
    send_frame(8'h55, good_par(8'h55), 1'b1);
    chk("lit_tmo_55", 32'({dout_ferr, dout_perr, dout}), 32'h055);
    pop1();
`endif

    // Random frames with a random reader and random flag clears
    rnd_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          logic [7:0] d;
          d = 8'($urandom);
          rx_en = ($urandom_range(0, 9) != 0);
          if ($urandom_range(0, 9) == 0)
            send_frame(d, 1'b0, 1'b1, 1'b1, 1);
          else
            send_frame(d, 1'($urandom), 1'($urandom_range(0, 5) != 0));
        end
        rx_en = 1'b1;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 rd_en = ($urandom_range(0, 3) == 0);
          clr_flags = ($urandom_range(0, 15) == 0);
        end
        rd_en = 1'b0;
        clr_flags = 1'b0;
      end
    join
    repeat (DEPTH) pop1();

    // Reset in the middle of a frame
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 5);
    do_reset();
    chk("lit_midrst_cnt", 32'(count), 32'd0);
    send_frame(8'h5A, good_par(8'h5A), 1'b1);
    chk("lit_midrst_next", 32'({dout_ferr, dout_perr, dout}), 32'h05A);
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
